// File: rtl/mips_load_writeback.sv
// Multi-cycle MIPS load unit: fetches one word over a req/ready handshake and
// writes the aligned, extended result into the register file with byte enables.
module mips_load_writeback #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] addr,
   input  logic [4:0]  rt_addr,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [4:0]  Rd_addr,
   output logic [31:0] Rd_in,
   output logic [3:0]  Rd_write_byte_en,
   output logic        busy,
   output logic        done,
   output logic        addr_err
);

   localparam logic [2:0] OP_LB  = 3'b000;
   localparam logic [2:0] OP_LH  = 3'b001;
   localparam logic [2:0] OP_LWL = 3'b010;
   localparam logic [2:0] OP_LW  = 3'b011;
   localparam logic [2:0] OP_LBU = 3'b100;
   localparam logic [2:0] OP_LHU = 3'b101;
   localparam logic [2:0] OP_LWR = 3'b110;

   localparam logic [15:0] LP_WAIT_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_WRITE = 2'd2,
      S_ERR   = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [2:0]  r_op;
   logic [1:0]  r_addr_lo;
   logic [4:0]  r_rt;
   logic [15:0] r_wait;

   // Legal op with an address that satisfies its natural alignment.
   function automatic logic f_legal(input logic [2:0] i_op, input logic [1:0] i_lo);
      logic v;
      case (i_op)
         OP_LH, OP_LHU: v = (i_lo[0] == 1'b0);
         OP_LW:         v = (i_lo == 2'b00);
         OP_LB, OP_LBU, OP_LWL, OP_LWR: v = 1'b1;
         default:       v = 1'b0;
      endcase
      return v;
   endfunction

   // Returns {byte_en, data}; B is the word shifted so the addressed byte sits at [7:0].
   function automatic logic [35:0] f_load(input logic [2:0] i_op, input logic [1:0] i_k,
                                          input logic [31:0] i_w);
      logic [31:0] b;
      logic [35:0] r;
      b = i_w >> {i_k, 3'b000};
      case (i_op)
         OP_LB:   r = {4'b1111, {{24{b[7]}}, b[7:0]}};
         OP_LBU:  r = {4'b1111, {24'd0, b[7:0]}};
         OP_LH:   r = {4'b1111, {{16{b[15]}}, b[15:0]}};
         OP_LHU:  r = {4'b1111, {16'd0, b[15:0]}};
         OP_LW:   r = {4'b1111, i_w};
         OP_LWL:  r = {4'b1111 << 2'(2'd3 - i_k), i_w << {2'(2'd3 - i_k), 3'b000}};
         OP_LWR:  r = {4'b1111 >> i_k, b};
         default: r = {4'b0000, 32'd0};
      endcase
      return r;
   endfunction

   // State register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; the timeout branch is skipped entirely when TIMEOUT is 0.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = f_legal(op, addr[1:0]) ? S_REQ : S_ERR;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_REQ: begin
            if (mem_ready) begin
               w_next = S_WRITE;
            end else if ((TIMEOUT != 0) && (r_wait == LP_WAIT_LAST)) begin
               w_next = S_ERR;
            end else begin
               w_next = S_REQ;
            end
         end
         S_WRITE: w_next = S_IDLE;
         S_ERR:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Registered outputs derived from the upcoming state, plus request latches.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_op             <= 3'd0;
         r_addr_lo        <= 2'd0;
         r_rt             <= 5'd0;
         r_wait           <= 16'd0;
         mem_req          <= 1'b0;
         mem_addr         <= 32'd0;
         Rd_addr          <= 5'd0;
         Rd_in            <= 32'd0;
         Rd_write_byte_en <= 4'd0;
         busy             <= 1'b0;
         done             <= 1'b0;
         addr_err         <= 1'b0;
      end else begin
         mem_req          <= (w_next == S_REQ);
         busy             <= (w_next != S_IDLE);
         done             <= (w_next == S_WRITE) || (w_next == S_ERR);
         addr_err         <= (w_next == S_ERR);
         Rd_write_byte_en <= 4'd0;
         if ((r_state == S_IDLE) && start) begin
            r_op      <= op;
            r_addr_lo <= addr[1:0];
            r_rt      <= rt_addr;
            mem_addr  <= {addr[31:2], 2'b00};
         end
         // Counter is zero whenever REQ is entered, since every other state clears it.
         if (r_state == S_REQ) begin
            r_wait <= r_wait + 16'd1;
         end else begin
            r_wait <= 16'd0;
         end
         if (w_next == S_WRITE) begin
            {Rd_write_byte_en, Rd_in} <= f_load(r_op, r_addr_lo, mem_rdata);
            Rd_addr                   <= r_rt;
         end
      end
   end

endmodule

// File: tb/tb_mips_load_writeback.sv
// Scoreboard bench for mips_load_writeback: stimulus pushes expected writes,
// a negedge monitor pops and compares on every done pulse.
module tb_mips_load_writeback;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic [3:0]  en;
      logic        err;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] addr = 32'd0;
   logic [4:0]  rt_addr = 5'd0;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [4:0]  Rd_addr;
   logic [31:0] Rd_in;
   logic [3:0]  Rd_write_byte_en;
   logic        busy;
   logic        done;
   logic        addr_err;

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass = 0;

   mips_load_writeback #(.TIMEOUT(16)) dut (
      .Clk(Clk), .Reset(Reset), .start(start), .op(op), .addr(addr), .rt_addr(rt_addr),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .Rd_addr(Rd_addr), .Rd_in(Rd_in), .Rd_write_byte_en(Rd_write_byte_en),
      .busy(busy), .done(done), .addr_err(addr_err)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every done pulse must match the oldest expected entry.
   always @(negedge Clk) begin
      if (!Reset && done) begin
         if (q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_done: got done=%b with empty scoreboard, expected none", done);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("addr_err", {31'd0, addr_err}, {31'd0, e.err});
            check("byte_en", {28'd0, Rd_write_byte_en}, {28'd0, e.en});
            if (!e.err) begin
               check("rd_in", Rd_in, e.data);
               check("rd_addr", {27'd0, Rd_addr}, {27'd0, e.rd});
            end
         end
      end
   end

   // wait_n: >=0 ready after that many idle REQ cycles, -1 never ready, -2 rejected at start.
   task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [4:0] rt,
                      input logic [31:0] rdata, input int wait_n, input logic [31:0] ed,
                      input logic [3:0] ee, input logic eerr, input bit poke);
      exp_t e;
      e.rd = rt; e.data = ed; e.en = ee; e.err = eerr;
      q.push_back(e);
      @(negedge Clk);
      start = 1'b1; op = o; addr = a; rt_addr = rt;
      @(posedge Clk); #1;
      start = 1'b0;
      if (wait_n == -2) begin
         check("err_no_req", {31'd0, mem_req}, 32'd0);
         check("err_done_next", {31'd0, done}, 32'd1);
         @(posedge Clk); #1;
         return;
      end
      check("req_up", {31'd0, mem_req}, 32'd1);
      check("mem_addr", mem_addr, {a[31:2], 2'b00});
      if (wait_n == -1) begin
         for (int c = 0; c < 15; c++) begin
            @(posedge Clk); #1;
         end
         check("req_held", {31'd0, mem_req}, 32'd1);
         @(posedge Clk); #1;
         check("timeout_done", {31'd0, done & addr_err}, 32'd1);
         check("timeout_req_drop", {31'd0, mem_req}, 32'd0);
         @(posedge Clk); #1;
         return;
      end
      for (int c = 0; c < wait_n; c++) begin
         if (poke && c == 0) begin
            start = 1'b1; op = 3'b011; addr = 32'h0000_0003; rt_addr = 5'd31;
         end
         @(posedge Clk); #1;
         start = 1'b0;
      end
      mem_ready = 1'b1; mem_rdata = rdata;
      @(posedge Clk); #1;
      mem_ready = 1'b0; mem_rdata = $urandom;
      check("done_latency", {31'd0, done}, 32'd1);
      check("req_drop", {31'd0, mem_req}, 32'd0);
      @(posedge Clk); #1;
      check("idle_busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      #1 Reset = 1'b1;
      #1;
      check("rst_outputs", {mem_req, busy, done, addr_err, Rd_write_byte_en, Rd_addr},
            32'd0);
      check("rst_rd_in", Rd_in, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      repeat (2) @(posedge Clk);
      @(negedge Clk) Reset = 1'b0;

      run(3'b000, 32'h0000_0101, 5'd3,  32'h1234_80FF, 0, 32'hFFFF_FF80, 4'b1111, 1'b0, 1'b0);
      run(3'b101, 32'h0000_0102, 5'd4,  32'hBEEF_0000, 0, 32'h0000_BEEF, 4'b1111, 1'b0, 1'b0);
      run(3'b001, 32'h0000_0102, 5'd5,  32'hBEEF_0000, 0, 32'hFFFF_BEEF, 4'b1111, 1'b0, 1'b0);
      run(3'b010, 32'h0000_0201, 5'd6,  32'hAABB_CCDD, 0, 32'hCCDD_0000, 4'b1100, 1'b0, 1'b0);
      run(3'b110, 32'h0000_0201, 5'd7,  32'hAABB_CCDD, 0, 32'h00AA_BBCC, 4'b0111, 1'b0, 1'b0);
      run(3'b100, 32'h0000_0003, 5'd8,  32'h8000_0000, 1, 32'h0000_0080, 4'b1111, 1'b0, 1'b0);
      run(3'b010, 32'h0000_0003, 5'd9,  32'h1122_3344, 0, 32'h1122_3344, 4'b1111, 1'b0, 1'b0);
      run(3'b110, 32'h0000_0000, 5'd10, 32'h1122_3344, 0, 32'h1122_3344, 4'b1111, 1'b0, 1'b0);
      run(3'b011, 32'h0000_0302, 5'd11, 32'h0, -2, 32'h0, 4'b0000, 1'b1, 1'b0);
      run(3'b111, 32'h0000_0300, 5'd12, 32'h0, -2, 32'h0, 4'b0000, 1'b1, 1'b0);
      run(3'b001, 32'h0000_0101, 5'd13, 32'h0, -2, 32'h0, 4'b0000, 1'b1, 1'b0);
      run(3'b011, 32'h0000_0400, 5'd14, 32'h0, -1, 32'h0, 4'b0000, 1'b1, 1'b0);
      run(3'b011, 32'h0000_0400, 5'd15, 32'h1357_9BDF, 4, 32'h1357_9BDF, 4'b1111, 1'b0, 1'b0);
      run(3'b011, 32'h0000_0500, 5'd0,  32'hCAFE_F00D, 0, 32'hCAFE_F00D, 4'b1111, 1'b0, 1'b0);
      run(3'b000, 32'h0000_0702, 5'd20, 32'h00C3_0000, 3, 32'hFFFF_FFC3, 4'b1111, 1'b0, 1'b1);

      @(negedge Clk);
      start = 1'b1; op = 3'b011; addr = 32'h0000_0600; rt_addr = 5'd7;
      @(posedge Clk); #1;
      start = 1'b0;
      check("pre_reset_req", {31'd0, mem_req}, 32'd1);
      @(posedge Clk); #3;
      Reset = 1'b1;
      #1;
      check("reset_req_drop", {31'd0, mem_req}, 32'd0);
      check("reset_busy_drop", {31'd0, busy}, 32'd0);
      check("reset_no_write", {28'd0, Rd_write_byte_en}, 32'd0);
      @(negedge Clk) Reset = 1'b0;
      mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      repeat (4) @(posedge Clk);
      #1;
      mem_ready = 1'b0;
      check("post_reset_idle", {31'd0, busy | done}, 32'd0);
      check("post_reset_rd_in", Rd_in, 32'd0);

      check("scoreboard_empty", q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
